jk_to_d_register: RTL and testbench
===================================

# jk_to_d_register

WIDTH-bit register built entirely from JK flip-flop cells, presenting plain D-register behaviour (load, hold, shift, count) to its user. It is the counterpart of our D-on-JK conversion: here each storage cell is a JK flip-flop, and a per-bit excitation encoder converts the wanted next state into J/K drive. It sits in the flip-flop conversion library as the JK-based data/count register used by the counter and shifter exercises.

## Interface
- WIDTH, 4: register width in bits (≥ 2).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all cells.
- mode  input  3  operation select: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 INC, 5 DEC; 6–7 behave as HOLD.
- en  input  1  qualifies mode; en=0 forces HOLD.
- d  input  WIDTH  parallel load data (LOAD only).
- sin  input  1  serial input bit (SHL enters at bit 0, SHR enters at bit WIDTH-1).
- q  output  WIDTH  register contents.
- qbar  output  WIDTH  bitwise ~q, continuous.
- sout  output  1  serial out: q[WIDTH-1] in SHL, q[0] in SHR, else 0.
- tc  output  1  terminal count: 1 when mode=INC, en=1 and q is all ones, or mode=DEC, en=1 and q is zero; else 0.

## Operation
- Next state nxt computed per cycle from mode/en:
  - HOLD: nxt=q.
  - LOAD: nxt=d.
  - SHL: nxt={q[WIDTH-2:0], sin}.
  - SHR: nxt={sin, q[WIDTH-1:1]}.
  - INC: nxt=q+1, modulo 2^WIDTH (all ones wraps to 0).
  - DEC: nxt=q-1, modulo 2^WIDTH (0 wraps to all ones).
- Excitation encoder per bit i, minimal-toggle form: J[i]=nxt[i]&~q[i], K[i]=~nxt[i]&q[i]. Hold therefore drives J=K=0; no cell ever sees J=K=1.
- Each cell implements JK semantics: 00 hold, 10 set, 01 reset, 11 toggle (toggle kept in cell for completeness; unreachable from encoder).
- reset wins over every mode and en; takes effect at the clock edge where it is sampled high.
- tc, sout, qbar are combinational from q, mode, en.

## Timing
- Single clock domain, all state updates on rising clk.
- Latency: command and data sampled at edge N; q reflects result after edge N (visible in cycle N+1).
- Reset: q=0, qbar=all ones, sout=0, tc=0 unless mode=DEC with en=1 (then tc=1, since q=0).
- reset asserted mid-count: q=0 after the edge regardless of mode; next operation resumes from 0.
- Back-to-back commands allowed every cycle; no stall, no handshake.
- Mode changes take effect the same edge they are sampled; no pipeline hazard.

## Configuration
- Macro JKD_EXCITE_OUT_EN.
- Defined: two extra outputs j_bus and k_bus (output, WIDTH each) expose the encoder J/K vectors for inspection; values combinational, same cycle as nxt.
- Not defined: ports absent, encoder internal only; functional behaviour of q identical.

## Structure
- Shared package jkd_pkg: mode encodings (MODE_HOLD … MODE_DEC) as named constants and a mode typedef of 3 bits.
- One sub-module: jk_ff_cell (clk, reset, j, k, q), instantiated WIDTH times via generate; top holds next-state mux and excitation encoder.

## Test plan
- Reset: drive q to 0xA via LOAD, assert reset with mode=INC -> q=0x0, qbar=0xF after one edge.
- LOAD/HOLD: mode=LOAD d=0x5 -> q=0x5; en=0 with mode=LOAD d=0xC for 3 cycles -> q stays 0x5.
- Count wrap: LOAD 0xE, INC×2 -> q=0xF (tc=1 while at 0xF with INC), then 0x0; DEC from 0x0 -> 0xF, tc=1 in the 0x0 cycle.
- Shift: LOAD 0x9, SHL sin=0 -> 0x2 with sout=1 before edge; SHR sin=1 from 0x2 -> 0x9.
- Excitation check (JKD_EXCITE_OUT_EN): q=0x3, LOAD 0x6 -> j_bus=0x4, k_bus=0x1; never j_bus&k_bus≠0 across random 1000-cycle run.
- Undefined modes 6/7 with en=1 -> q unchanged, tc=0, sout=0.

Source files
------------

// File: rtl/jkd_pkg.sv
// Shared definitions for the JK-based data/count register.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package jkd_pkg;

    // 3-bit operation select; encodings 6 and 7 are treated as HOLD.
    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'd0;
    localparam mode_t MODE_LOAD = 3'd1;
    localparam mode_t MODE_SHL  = 3'd2;
    localparam mode_t MODE_SHR  = 3'd3;
    localparam mode_t MODE_INC  = 3'd4;
    localparam mode_t MODE_DEC  = 3'd5;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop storage cell: 00 hold, 10 set, 01 reset, 11 toggle.
// Latency: q updates on the rising clk edge where j/k are sampled.
// Backpressure: none; j/k accepted every cycle.
//
// Ports: clk (rising edge), reset (sync, active-high, clears q),
//        j, k (excitation inputs), q (stored bit).
module jk_ff_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            // Toggle is unreachable from the minimal-toggle encoder but
            // kept so the cell is a complete JK flip-flop.
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_to_d_register.sv
// D-style register (hold/load/shift/inc/dec) whose storage is WIDTH JK cells.
// Latency: command sampled at edge N, result on q after edge N.
// Backpressure: none; a new command is accepted every cycle.
//
// Ports: clk, reset (sync, active-high), mode[2:0], en, d[WIDTH-1:0], sin
//        -> q, qbar, sout, tc.  Optional macro JKD_EXCITE_OUT_EN adds
//        j_bus/k_bus outputs exposing the per-bit J/K excitation.
module jk_to_d_register
    import jkd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout,
    output logic             tc
`ifdef JKD_EXCITE_OUT_EN
    ,
    output logic [WIDTH-1:0] j_bus,
    output logic [WIDTH-1:0] k_bus
`endif
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_t            eff_mode;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic [WIDTH-1:0] cell_q;

    // en=0 and the unused encodings all collapse onto HOLD here, so the
    // next-state mux and the status outputs only see legal modes.
    always_comb begin
        eff_mode = MODE_HOLD;
        if (en && (mode <= MODE_DEC)) begin
            eff_mode = mode_t'(mode);
        end
    end

    always_comb begin
        nxt = cell_q;
        case (eff_mode)
            MODE_LOAD: nxt = d;
            MODE_SHL:  nxt = {cell_q[WIDTH-2:0], sin};
            MODE_SHR:  nxt = {sin, cell_q[WIDTH-1:1]};
            MODE_INC:  nxt = cell_q + ONE;
            MODE_DEC:  nxt = cell_q - ONE;
            default:   nxt = cell_q;
        endcase
    end

    // Minimal-toggle excitation: set only bits that must rise, clear only
    // bits that must fall. J and K are never both high for a bit.
    assign j_vec = nxt & ~cell_q;
    assign k_vec = ~nxt & cell_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (cell_q[i])
        );
    end

    assign q    = cell_q;
    assign qbar = ~cell_q;

    always_comb begin
        sout = 1'b0;
        tc   = 1'b0;
        case (eff_mode)
            MODE_SHL: sout = cell_q[WIDTH-1];
            MODE_SHR: sout = cell_q[0];
            MODE_INC: tc   = &cell_q;
            MODE_DEC: tc   = ~|cell_q;
            default: begin
                sout = 1'b0;
                tc   = 1'b0;
            end
        endcase
    end

`ifdef JKD_EXCITE_OUT_EN
    assign j_bus = j_vec;
    assign k_bus = k_vec;
`endif

endmodule

// File: tb/tb_jk_to_d_register.sv
// Randomized + directed scoreboard bench for jk_to_d_register.
// Latency: checks combinational outputs before each edge, q after it.
// Backpressure: none; one command is issued every cycle.
module tb_jk_to_d_register;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int TOPB = 1 << (W - 1);

    logic         clk;
    logic         reset;
    logic [2:0]   mode;
    logic         en;
    logic [W-1:0] d;
    logic         sin;
    logic [W-1:0] q;
    logic [W-1:0] qbar;
    logic         sout;
    logic         tc;
`ifdef JKD_EXCITE_OUT_EN
    logic [W-1:0] j_bus;
    logic [W-1:0] k_bus;
`endif

    jk_to_d_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .en    (en),
        .d     (d),
        .sin   (sin),
        .q     (q),
        .qbar  (qbar),
        .sout  (sout),
        .tc    (tc)
`ifdef JKD_EXCITE_OUT_EN
        ,
        .j_bus (j_bus),
        .k_bus (k_bus)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit chk_comb;
        int qbar;
        int sout;
        int tc;
        int j;
        int k;
        int q_next;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mq     = 0;
    bit   mq_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic on the register value as an integer.
    task automatic step(input bit r, input int m, input bit e, input int dd, input bit s);
        exp_t x;
        int   em;
        int   nq;
        @(posedge clk);
        #2;
        reset = r;
        mode  = m[2:0];
        en    = e;
        d     = dd[W-1:0];
        sin   = s;
        em = e ? m : 0;
        if (em > 5) em = 0;
        case (em)
            1:       nq = dd & MASK;
            2:       nq = (mq * 2 + int'(s)) % (MASK + 1);
            3:       nq = int'(s) * TOPB + mq / 2;
            4:       nq = (mq + 1) % (MASK + 1);
            5:       nq = (mq + MASK) % (MASK + 1);
            default: nq = mq;
        endcase
        x.chk_comb = mq_valid;
        x.qbar     = MASK - mq;
        x.sout     = (em == 2) ? (mq / TOPB) : (em == 3) ? (mq % 2) : 0;
        x.tc       = ((em == 4 && mq == MASK) || (em == 5 && mq == 0)) ? 1 : 0;
        x.j        = nq & ~mq & MASK;
        x.k        = ~nq & mq & MASK;
        if (r) nq = 0;
        x.q_next   = nq;
        sb.push_back(x);
        mq       = nq;
        mq_valid = 1'b1;
    endtask

    // Monitor: combinational outputs mid-cycle, registered result after edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk_comb) begin
                    chk("qbar", int'(qbar), e.qbar);
                    chk("sout", int'(sout), e.sout);
                    chk("tc",   int'(tc),   e.tc);
`ifdef JKD_EXCITE_OUT_EN
                    chk("j_bus", int'(j_bus), e.j);
                    chk("k_bus", int'(k_bus), e.k);
                    chk("j_and_k", int'(j_bus & k_bus), 0);
`endif
                end
                @(posedge clk);
                #1;
                chk("q", int'(q), e.q_next);
            end
        end
    end

    initial begin
        int wait_cyc;
        reset = 1'b1;
        mode  = 3'd0;
        en    = 1'b0;
        d     = '0;
        sin   = 1'b0;

        step(1, 0, 0, 0, 0);          // initial reset
        step(0, 0, 1, 0, 0);          // reset state visible: q=0, qbar=F
        step(0, 1, 1, 'hA, 0);        // LOAD 0xA
        step(1, 4, 1, 0, 0);          // reset wins over INC
        step(0, 5, 1, 0, 0);          // DEC at 0: tc=1, wraps to F
        step(0, 1, 1, 'h5, 0);        // LOAD 5
        step(0, 1, 0, 'hC, 0);        // en=0 holds
        step(0, 1, 0, 'hC, 0);
        step(0, 1, 0, 'hC, 0);
        step(0, 1, 1, 'hE, 0);        // LOAD E
        step(0, 4, 1, 0, 0);          // -> F
        step(0, 4, 1, 0, 0);          // tc=1, -> 0
        step(0, 5, 1, 0, 0);          // tc=1, -> F
        step(0, 1, 1, 'h9, 0);        // LOAD 9
        step(0, 2, 1, 0, 0);          // SHL sin=0, sout=1 -> 2
        step(0, 3, 1, 0, 1);          // SHR sin=1 -> 9
        step(0, 1, 1, 'h3, 0);        // LOAD 3
        step(0, 1, 1, 'h6, 0);        // LOAD 6: J=4, K=1
        step(0, 6, 1, 'hF, 1);        // undefined modes hold
        step(0, 7, 1, 'hF, 1);

        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 31) == 0),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, MASK)),
                 $urandom_range(0, 1) == 1);
        end

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
